seq_pattern_detector: RTL

//  Parametrised serial pattern detector. Generalises the fixed 3-bit "110" detector:
//  - pattern width is set by parameter
//  - pattern and don't-care mask are programmable at runtime
//  - overlapping or non-overlapping match mode is selectable
//  - input bits are qualified by a valid strobe; gaps are allowed
//  - a saturating match counter is provided

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/seq_match_counter.sv | 36 +++
 rtl/seq_pattern_detector.sv | 98 +++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic {MODE_NONOVL, MODE_OVL} seq_mode_t;

  // Fill counter must represent 0..pat_w inclusive.
  function automatic int unsigned fill_cnt_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; clear has priority over increment.
module seq_match_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (clr) begin
      w_count_nxt = '0;
    end else if (inc && (r_count != CntMax)) begin
      w_count_nxt = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial pattern detector with don't-care mask, overlap mode,
// valid-qualified input and a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W       = 3,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [PAT_W-1:0] DEF_PATTERN = 3'b110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             seq_in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic             window_full
);

  localparam int unsigned FILL_W = fill_cnt_w(PAT_W);
  localparam logic [FILL_W-1:0] FillFull = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  r_pattern, w_pattern_nxt;
  logic [PAT_W-1:0]  r_mask, w_mask_nxt;
  seq_mode_t         r_mode, w_mode_nxt;
  logic [PAT_W-1:0]  r_hist, w_hist_nxt;
  logic [FILL_W-1:0] r_fill, w_fill_nxt;
  logic              r_detect;

  logic              w_accept;
  logic              w_full;
  logic [PAT_W-1:0]  w_nhist;
  logic [FILL_W-1:0] w_nfill;
  logic              w_match;

  always_comb begin
    w_accept = in_valid & ~cfg_load;
    w_full   = (r_fill == FillFull);
    w_nhist  = {r_hist[PAT_W-2:0], seq_in};
    w_nfill  = w_full ? r_fill : r_fill + FILL_W'(1);
    w_match  = w_accept && (w_nfill == FillFull) && (((w_nhist ^ r_pattern) & r_mask) == '0);
  end

  always_comb begin
    w_pattern_nxt = r_pattern;
    w_mask_nxt    = r_mask;
    w_mode_nxt    = r_mode;
    w_hist_nxt    = r_hist;
    w_fill_nxt    = r_fill;
    if (cfg_load) begin
      // Load wins over a coincident input bit and flushes the window.
      w_pattern_nxt = cfg_pattern;
      w_mask_nxt    = cfg_mask;
      w_mode_nxt    = cfg_overlap ? MODE_OVL : MODE_NONOVL;
      w_hist_nxt    = '0;
      w_fill_nxt    = '0;
    end else if (w_accept) begin
      w_hist_nxt = w_nhist;
      w_fill_nxt = (w_match && (r_mode == MODE_NONOVL)) ? '0 : w_nfill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= DEF_PATTERN;
      r_mask    <= '1;
      r_mode    <= MODE_OVL;
      r_hist    <= '0;
      r_fill    <= '0;
      r_detect  <= 1'b0;
    end else begin
      r_pattern <= w_pattern_nxt;
      r_mask    <= w_mask_nxt;
      r_mode    <= w_mode_nxt;
      r_hist    <= w_hist_nxt;
      r_fill    <= w_fill_nxt;
      r_detect  <= w_match;
    end
  end

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_match),
    .clr   (cnt_clr),
    .count (match_count)
  );

  assign detect      = r_detect;
  assign window_full = w_full;

endmodule
